// File: rtl/cfg_pkg.sv
// cfg_pkg: system-level configuration shared across the stack subsystem.
//   ENGS_N : number of engines issuing stack commands.
package cfg_pkg;
    localparam int unsigned ENGS_N = 4;
endpackage

// File: rtl/stk_pkg.sv
// stk_pkg: stack command/response types and stack sizing defaults.
//   opcode_t : NOP / PUSH / POP / CLR
//   err_t    : rejection cause reported to an engine
package stk_pkg;
    localparam int unsigned STK_DEPTH = 16;
    localparam int unsigned DAT_W     = 128;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        CLR  = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        OVERFLOW  = 2'd1,
        UNDERFLOW = 2'd2
    } err_t;
endpackage

// File: rtl/stk_rr_arb.sv
// stk_rr_arb: combinational round-robin grant selection.
//   req     : request vector
//   ptr     : index where the search starts (wraps N-1 -> 0)
//   gnt     : one-hot grant
//   any     : a grant was made
//   idx     : binary index of the grantee
//   ptr_nxt : pointer to use after this grant (grantee + 1 mod N)
module stk_rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [PW-1:0] idx,
    output logic [PW-1:0] ptr_nxt
);

    always_comb begin : search
        int unsigned k;
        k       = 0;
        gnt     = '0;
        any     = 1'b0;
        idx     = '0;
        ptr_nxt = ptr;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt[k]  = 1'b1;
                idx     = PW'(k);
                ptr_nxt = PW'((k + 1) % N);
            end
        end
    end

endmodule

// File: rtl/stk_arb.sv
// stk_arb: arbitrates per-engine stack commands onto a single stack pipe.
// Tracks per-engine stack occupancy, rejects overflowing pushes and
// underflowing pops, and returns a response strobe PIPE_LAT cycles after
// each issued command.
//   clk, rst       : clock, synchronous active-high reset
//   i_cmd_vld      : per-engine command request
//   i_cmd_opcode   : per-engine opcode
//   i_cmd_dat      : per-engine push data
//   o_cmd_ack      : one-hot combinational grant (command consumed)
//   o_pipe_*       : registered command issued to the stack pipe
//   o_rsp_vld      : one-hot response strobe to the issuing engine
//   o_err_vld      : one-hot rejection strobe, o_err_code gives the cause
module stk_arb
    import stk_pkg::*;
#(
    parameter int unsigned ENGS_N    = cfg_pkg::ENGS_N,
    parameter int unsigned STK_DEPTH = stk_pkg::STK_DEPTH,
    parameter int unsigned PIPE_LAT  = 3,
    localparam int unsigned EW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int unsigned OW = $clog2(STK_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ENGS_N-1:0]             i_cmd_vld,
    input  opcode_t [ENGS_N-1:0]          i_cmd_opcode,
    input  logic [ENGS_N-1:0][DAT_W-1:0]  i_cmd_dat,
    output logic [ENGS_N-1:0]             o_cmd_ack,
    output logic                          o_pipe_vld,
    output opcode_t                       o_pipe_opcode,
    output logic [EW-1:0]                 o_pipe_eng,
    output logic [DAT_W-1:0]              o_pipe_dat,
    output logic [ENGS_N-1:0]             o_rsp_vld,
    output logic [ENGS_N-1:0]             o_err_vld,
    output err_t                          o_err_code
);

    logic [ENGS_N-1:0] eligible;
    logic [ENGS_N-1:0] gnt;
    logic              any;
    logic [EW-1:0]     gidx;
    logic [EW-1:0]     rr_ptr;
    logic [EW-1:0]     ptr_nxt;
    logic [OW-1:0]     occ [ENGS_N];
    opcode_t           sel_op;
    logic [OW-1:0]     sel_occ;
    logic              reject;
    logic              accept;

    // Response delay line, fed from the issued-command register so that the
    // last stage lines up exactly PIPE_LAT cycles after o_pipe_vld.
    logic [PIPE_LAT-1:0] sr_vld;
    logic [EW-1:0]       sr_eng [PIPE_LAT];

    always_comb begin
        eligible = '0;
        for (int unsigned e = 0; e < ENGS_N; e++) begin
            eligible[e] = i_cmd_vld[e] && (i_cmd_opcode[e] != NOP);
        end
    end

    stk_rr_arb #(
        .N  (ENGS_N),
        .PW (EW)
    ) u_rr (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .any     (any),
        .idx     (gidx),
        .ptr_nxt (ptr_nxt)
    );

    always_comb begin
        sel_op  = i_cmd_opcode[gidx];
        sel_occ = occ[gidx];
        reject  = any && (((sel_op == PUSH) && (sel_occ == OW'(STK_DEPTH))) ||
                          ((sel_op == POP)  && (sel_occ == '0)));
        accept  = any && !reject;
        o_cmd_ack = rst ? '0 : gnt;
    end

    always_comb begin
        o_rsp_vld = '0;
        if (sr_vld[PIPE_LAT-1]) begin
            o_rsp_vld[sr_eng[PIPE_LAT-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            o_pipe_vld    <= 1'b0;
            o_pipe_opcode <= NOP;
            o_pipe_eng    <= '0;
            o_pipe_dat    <= '0;
            o_err_vld     <= '0;
            o_err_code    <= ERR_NONE;
            sr_vld        <= '0;
            for (int unsigned e = 0; e < ENGS_N; e++) begin
                occ[e] <= '0;
            end
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                sr_eng[i] <= '0;
            end
        end else begin
            if (any) begin
                rr_ptr <= ptr_nxt;
            end

            o_pipe_vld <= accept;
            if (accept) begin
                o_pipe_opcode <= sel_op;
                o_pipe_eng    <= gidx;
                o_pipe_dat    <= i_cmd_dat[gidx];
                case (sel_op)
                    PUSH:    occ[gidx] <= sel_occ + OW'(1);
                    POP:     occ[gidx] <= sel_occ - OW'(1);
                    CLR:     occ[gidx] <= '0;
                    default: ;
                endcase
            end

            o_err_vld <= reject ? gnt : '0;
            if (reject) begin
                o_err_code <= (sel_op == PUSH) ? OVERFLOW : UNDERFLOW;
            end

            sr_vld[0] <= o_pipe_vld;
            sr_eng[0] <= o_pipe_eng;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_eng[i] <= sr_eng[i-1];
            end
        end
    end

endmodule

// File: tb/tb_stk_arb.sv
// tb_stk_arb: directed, table-driven bench for stk_arb (4 engines,
// depth 16, pipe latency 3) plus hand-written multi-cycle sequences.
module tb_stk_arb;
    import stk_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           cmd_vld;
    opcode_t [3:0]        cmd_op;
    logic [3:0][127:0]    cmd_dat;
    logic [3:0]           cmd_ack;
    logic                 pipe_vld;
    opcode_t              pipe_opcode;
    logic [1:0]           pipe_eng;
    logic [127:0]         pipe_dat;
    logic [3:0]           rsp_vld;
    logic [3:0]           err_vld;
    err_t                 err_code;

    int checks   = 0;
    int failures = 0;

    stk_arb #(
        .ENGS_N    (4),
        .STK_DEPTH (16),
        .PIPE_LAT  (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_vld     (cmd_vld),
        .i_cmd_opcode  (cmd_op),
        .i_cmd_dat     (cmd_dat),
        .o_cmd_ack     (cmd_ack),
        .o_pipe_vld    (pipe_vld),
        .o_pipe_opcode (pipe_opcode),
        .o_pipe_eng    (pipe_eng),
        .o_pipe_dat    (pipe_dat),
        .o_rsp_vld     (rsp_vld),
        .o_err_vld     (err_vld),
        .o_err_code    (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        opcode_t    op [4];
        logic [3:0] ack;
        logic       pvld;
        logic [1:0] peng;
        opcode_t    pop;
        logic [3:0] err;
        err_t       ecode;
        logic [3:0] rsp;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [127:0] dat_of(int e, int k);
        return {32'hDA7A_0000 + 32'(e), 32'(k), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic vec_t mk(logic [3:0] vld, opcode_t o0, opcode_t o1,
                                opcode_t o2, opcode_t o3, logic [3:0] ack,
                                logic pvld, logic [1:0] peng, opcode_t pop,
                                logic [3:0] err, err_t ecode, logic [3:0] rsp);
        vec_t v;
        v.vld = vld;
        v.op[0] = o0; v.op[1] = o1; v.op[2] = o2; v.op[3] = o3;
        v.ack = ack; v.pvld = pvld; v.peng = peng; v.pop = pop;
        v.err = err; v.ecode = ecode; v.rsp = rsp;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, opcode_t o0, opcode_t o1,
                         opcode_t o2, opcode_t o3, int tag);
        cmd_vld   = v;
        cmd_op[0] = o0; cmd_op[1] = o1; cmd_op[2] = o2; cmd_op[3] = o3;
        for (int e = 0; e < 4; e++) cmd_dat[e] = dat_of(e, tag);
    endtask

    task automatic idle();
        drive(4'b0000, NOP, NOP, NOP, NOP, 0);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges with every engine requesting, and checks
    // that nothing is acked and all outputs sit at their reset values.
    task automatic do_reset();
        rst = 1'b1;
        drive(4'b1111, PUSH, PUSH, PUSH, PUSH, 0);
        edge_step();
        edge_step();
        chk("rst_ack",     cmd_ack, 4'b0000);
        chk("rst_pvld",    pipe_vld, 1'b0);
        chk("rst_popcode", pipe_opcode, NOP);
        chk("rst_peng",    pipe_eng, 2'd0);
        chk("rst_pdat",    pipe_dat, 128'd0);
        chk("rst_rsp",     rsp_vld, 4'b0000);
        chk("rst_err",     err_vld, 4'b0000);
        chk("rst_ecode",   err_code, ERR_NONE);
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Round-robin over all engines, NOP filtering, pops down to empty,
        // then an underflowing pop that must never produce a response.
        tbl[0]  = mk(4'b1111, PUSH, PUSH, PUSH, PUSH, 4'b0001, 1, 2'd0, PUSH, 4'b0000, ERR_NONE,  4'b0000);
        tbl[1]  = mk(4'b1111, PUSH, PUSH, PUSH, PUSH, 4'b0010, 1, 2'd1, PUSH, 4'b0000, ERR_NONE,  4'b0000);
        tbl[2]  = mk(4'b1111, PUSH, PUSH, PUSH, PUSH, 4'b0100, 1, 2'd2, PUSH, 4'b0000, ERR_NONE,  4'b0000);
        tbl[3]  = mk(4'b1111, PUSH, PUSH, PUSH, PUSH, 4'b1000, 1, 2'd3, PUSH, 4'b0000, ERR_NONE,  4'b0001);
        tbl[4]  = mk(4'b1111, PUSH, PUSH, PUSH, PUSH, 4'b0001, 1, 2'd0, PUSH, 4'b0000, ERR_NONE,  4'b0010);
        tbl[5]  = mk(4'b0011, NOP,  PUSH, NOP,  NOP,  4'b0010, 1, 2'd1, PUSH, 4'b0000, ERR_NONE,  4'b0100);
        tbl[6]  = mk(4'b0000, NOP,  NOP,  NOP,  NOP,  4'b0000, 0, 2'd0, NOP,  4'b0000, ERR_NONE,  4'b1000);
        tbl[7]  = mk(4'b0010, NOP,  POP,  NOP,  NOP,  4'b0010, 1, 2'd1, POP,  4'b0000, ERR_NONE,  4'b0001);
        tbl[8]  = mk(4'b0010, NOP,  POP,  NOP,  NOP,  4'b0010, 1, 2'd1, POP,  4'b0000, ERR_NONE,  4'b0010);
        tbl[9]  = mk(4'b0010, NOP,  POP,  NOP,  NOP,  4'b0010, 0, 2'd0, NOP,  4'b0010, UNDERFLOW, 4'b0000);
        tbl[10] = mk(4'b0000, NOP,  NOP,  NOP,  NOP,  4'b0000, 0, 2'd0, NOP,  4'b0000, ERR_NONE,  4'b0010);
        tbl[11] = mk(4'b0000, NOP,  NOP,  NOP,  NOP,  4'b0000, 0, 2'd0, NOP,  4'b0000, ERR_NONE,  4'b0010);
        tbl[12] = mk(4'b0000, NOP,  NOP,  NOP,  NOP,  4'b0000, 0, 2'd0, NOP,  4'b0000, ERR_NONE,  4'b0000);

        do_reset();
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].vld, tbl[k].op[0], tbl[k].op[1], tbl[k].op[2], tbl[k].op[3], k);
            #1;
            chk($sformatf("v%0d_ack", k), cmd_ack, tbl[k].ack);
            edge_step();
            chk($sformatf("v%0d_pvld", k), pipe_vld, tbl[k].pvld);
            if (tbl[k].pvld) begin
                chk($sformatf("v%0d_peng", k), pipe_eng, tbl[k].peng);
                chk($sformatf("v%0d_pop", k), pipe_opcode, tbl[k].pop);
                chk($sformatf("v%0d_pdat", k), pipe_dat, dat_of(int'(tbl[k].peng), k));
            end
            chk($sformatf("v%0d_err", k), err_vld, tbl[k].err);
            if (tbl[k].err != 4'b0000)
                chk($sformatf("v%0d_ecode", k), err_code, tbl[k].ecode);
            chk($sformatf("v%0d_rsp", k), rsp_vld, tbl[k].rsp);
        end

        // Engine 2 pushes 17 times alone: 16 issued, 17th overflows.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drive(4'b0100, NOP, NOP, PUSH, NOP, 100 + n);
            #1;
            chk($sformatf("ovf%0d_ack", n), cmd_ack, 4'b0100);
            edge_step();
            chk($sformatf("ovf%0d_pvld", n), pipe_vld, (n < 16) ? 1'b1 : 1'b0);
            chk($sformatf("ovf%0d_err", n), err_vld, (n < 16) ? 4'b0000 : 4'b0100);
        end
        chk("ovf_ecode", err_code, OVERFLOW);
        idle();
        for (int n = 0; n < 3; n++) begin
            edge_step();
            chk($sformatf("ovf_tail%0d_err", n), err_vld, 4'b0000);
            chk($sformatf("ovf_tail%0d_rsp", n), rsp_vld, (n < 2) ? 4'b0100 : 4'b0000);
        end

        // Engine 3 at occupancy 5: CLR then POP back-to-back.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(4'b1000, NOP, NOP, NOP, PUSH, 200 + n);
            edge_step();
        end
        drive(4'b1000, NOP, NOP, NOP, CLR, 210);
        #1;
        chk("clr_ack", cmd_ack, 4'b1000);
        edge_step();
        chk("clr_pvld", pipe_vld, 1'b1);
        chk("clr_pop",  pipe_opcode, CLR);
        chk("clr_peng", pipe_eng, 2'd3);
        drive(4'b1000, NOP, NOP, NOP, POP, 211);
        #1;
        chk("clrpop_ack", cmd_ack, 4'b1000);
        edge_step();
        chk("clrpop_pvld",  pipe_vld, 1'b0);
        chk("clrpop_err",   err_vld, 4'b1000);
        chk("clrpop_ecode", err_code, UNDERFLOW);
        idle();

        // Reset with three responses in flight; pointer must restart at 0.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(4'b1111, PUSH, PUSH, PUSH, PUSH, 300 + n);
            edge_step();
        end
        rst = 1'b1;
        #1;
        chk("flush_ack_in_rst", cmd_ack, 4'b0000);
        edge_step();
        chk("flush_rsp0", rsp_vld, 4'b0000);
        edge_step();
        chk("flush_rsp1", rsp_vld, 4'b0000);
        rst = 1'b0;
        drive(4'b1100, NOP, NOP, PUSH, PUSH, 310);
        #1;
        chk("flush_first_ack", cmd_ack, 4'b0100);
        edge_step();
        chk("flush_pvld", pipe_vld, 1'b1);
        chk("flush_peng", pipe_eng, 2'd2);
        chk("flush_rsp2", rsp_vld, 4'b0000);
        idle();
        for (int n = 0; n < 3; n++) begin
            edge_step();
            chk($sformatf("flush_tail%0d_rsp", n), rsp_vld, (n < 2) ? 4'b0000 : 4'b0100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
